servant_irq_ctrl: RTL and testbench

Small interrupt controller that sits directly downstream of the servant timer and other peripheral interrupt lines, and drives the single external interrupt input of the SERV core. It latches and masks up to N_SRC interrupt sources and arbitrates them by fixed priority (lowest index wins). It exposes a claim/complete register interface on the servant Wishbone bus, so firmware can identify and retire the active source. Source 0 is by convention the timer `o_irq`.

---
 rtl/servant_irq_pkg.sv | 22 ++
 rtl/servant_irq_prio.sv | 23 ++
 rtl/servant_irq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_servant_irq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_irq_pkg.sv
// Shared constants for the servant interrupt controller: register map,
// bus FSM states and the claim-id width helper.
package servant_irq_pkg;

  // Word offsets on the Wishbone slave port
  localparam logic [1:0] REG_PENDING  = 2'd0;
  localparam logic [1:0] REG_ENABLE   = 2'd1;
  localparam logic [1:0] REG_CLAIM    = 2'd2;
  localparam logic [1:0] REG_COMPLETE = 2'd3;

  // Bus handshake: one ack cycle, then at least one idle cycle
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  // Width needed to hold a claim value 0..n (0 means "nothing pending")
  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/servant_irq_prio.sv
// Fixed-priority encoder: the lowest set request bit wins.
module servant_irq_prio
  import servant_irq_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest requesting index is the final winner
  always_comb begin
    valid = 1'b0;
    id    = {ID_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/servant_irq_ctrl.sv
// Interrupt controller for the SERV core: latches edge/level sources, masks
// them with enable and in-service bits, and offers claim/complete registers
// on the servant Wishbone bus. Source 0 is normally the timer interrupt.
module servant_irq_ctrl
  import servant_irq_pkg::*;
#(
  parameter int               N_SRC          = 4,
  parameter logic [N_SRC-1:0] EDGE_MASK      = {N_SRC{1'b0}},
  parameter string            RESET_STRATEGY = ""
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  output logic             o_irq,
  input  logic [1:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack
);

  localparam int               ID_W       = id_width(N_SRC);
  localparam logic [N_SRC-1:0] LEVEL_MASK = ~EDGE_MASK;
  localparam bit               RST_REGS   = (RESET_STRATEGY != "NONE");

  bus_state_e       state_r;
  bus_state_e       state_nxt_s;
  logic [N_SRC-1:0] src_q_r;
  logic [N_SRC-1:0] pend_edge_r;
  logic [N_SRC-1:0] en_r;
  logic [N_SRC-1:0] insvc_r;

  logic [N_SRC-1:0] pend_s;
  logic [N_SRC-1:0] req_s;
  logic [N_SRC-1:0] rise_s;
  logic             prio_valid_s;
  logic [ID_W-1:0]  prio_id_s;

  logic             acc_s;
  logic             wr_s;
  logic             rd_s;
  logic [31:0]      rd_data_s;
  logic [N_SRC-1:0] w1c_clr_s;
  logic [N_SRC-1:0] claim_set_s;
  logic [N_SRC-1:0] cmp_clr_s;
  logic             en_wr_s;

  // Visible pending vector and the set of sources able to interrupt
  always_comb begin
    pend_s = (pend_edge_r & EDGE_MASK) | (src_q_r & LEVEL_MASK);
    req_s  = pend_s & en_r & ~insvc_r;
    rise_s = i_src & ~src_q_r;
  end

  servant_irq_prio #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .req   (req_s),
    .valid (prio_valid_s),
    .id    (prio_id_s)
  );

  // Bus FSM next state: accept on cyc, always return to idle after the ack
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_wb_cyc) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Register decode: read mux and one-shot side effects of the accepted access
  always_comb begin
    acc_s       = (state_r == ST_IDLE) & i_wb_cyc & ~i_rst;
    wr_s        = acc_s & i_wb_we;
    rd_s        = acc_s & ~i_wb_we;
    rd_data_s   = 32'd0;
    w1c_clr_s   = {N_SRC{1'b0}};
    claim_set_s = {N_SRC{1'b0}};
    cmp_clr_s   = {N_SRC{1'b0}};
    en_wr_s     = 1'b0;
    case (i_wb_adr)
      REG_PENDING: begin
        rd_data_s = 32'(pend_s);
        if (wr_s) begin
          w1c_clr_s = i_wb_dat[N_SRC-1:0] & EDGE_MASK;
        end else begin
          w1c_clr_s = {N_SRC{1'b0}};
        end
      end
      REG_ENABLE: begin
        rd_data_s = 32'(en_r);
        en_wr_s   = wr_s;
      end
      REG_CLAIM: begin
        rd_data_s = prio_valid_s ? (32'(prio_id_s) + 32'd1) : 32'd0;
        for (int i = 0; i < N_SRC; i++) begin
          claim_set_s[i] = rd_s & prio_valid_s & (prio_id_s == ID_W'(i));
        end
      end
      REG_COMPLETE: begin
        rd_data_s = 32'd0;
        for (int i = 0; i < N_SRC; i++) begin
          cmp_clr_s[i] = wr_s & (i_wb_dat == 32'(i + 1));
        end
      end
      default: rd_data_s = 32'd0;
    endcase
  end

  // Bus FSM state and registered acknowledge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      o_wb_ack <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      o_wb_ack <= (state_nxt_s == ST_ACK);
    end
  end

  // Registered copy of the sources, used for edge detect and level pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q_r <= {N_SRC{1'b0}};
    end else begin
      src_q_r <= i_src;
    end
  end

  // Pending/enable/in-service state; a new edge wins over a same-cycle clear
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_REGS) begin
      pend_edge_r <= {N_SRC{1'b0}};
      en_r        <= {N_SRC{1'b0}};
      insvc_r     <= {N_SRC{1'b0}};
    end else begin
      pend_edge_r <= ((pend_edge_r & ~(w1c_clr_s | claim_set_s)) | rise_s) & EDGE_MASK;
      insvc_r     <= (insvc_r & ~cmp_clr_s) | claim_set_s;
      if (en_wr_s) begin
        en_r <= i_wb_dat[N_SRC-1:0];
      end
    end
  end

  // Registered interrupt request and read data captured with the ack
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq    <= 1'b0;
      o_wb_rdt <= 32'd0;
    end else begin
      o_irq <= |req_s;
      if (acc_s) begin
        o_wb_rdt <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_servant_irq_ctrl.sv
// Bench for servant_irq_ctrl: directed scenarios plus randomized traffic,
// checked by a cycle-level reference model and a read-data scoreboard.
module tb_servant_irq_ctrl;

  localparam int       N    = 4;
  localparam bit [3:0] EDGE = 4'b0001;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_src = 4'd0;
  logic        o_irq;
  logic [1:0]  i_wb_adr = 2'd0;
  logic [31:0] i_wb_dat = 32'd0;
  logic        i_wb_we  = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int last_lat = 0;

  bit [31:0] sb_q[$];

  // Reference model state
  bit [3:0] m_srcq  = 4'd0;
  bit [3:0] m_pend  = 4'd0;
  bit [3:0] m_en    = 4'd0;
  bit [3:0] m_insvc = 4'd0;
  bit       m_irq   = 1'b0;
  bit       m_ack   = 1'b0;

  servant_irq_ctrl #(
    .N_SRC          (N),
    .EDGE_MASK      (EDGE),
    .RESET_STRATEGY ("")
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_src    (i_src),
    .o_irq    (o_irq),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model, evaluated once per rising edge from the register rules
  task automatic model_step();
    bit [3:0]  pend_v, req_v, clr_v, set_v, cmp_v, en_v;
    bit [31:0] rv;
    int        lowest;
    bit        acc;
    if (i_rst) begin
      m_srcq = 4'd0; m_pend = 4'd0; m_en = 4'd0; m_insvc = 4'd0;
      m_irq = 1'b0; m_ack = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) pend_v[i] = EDGE[i] ? m_pend[i] : m_srcq[i];
    req_v  = pend_v & m_en & ~m_insvc;
    lowest = -1;
    for (int i = 0; i < N; i++) if (lowest < 0 && req_v[i]) lowest = i;
    clr_v = 4'd0; set_v = 4'd0; cmp_v = 4'd0; en_v = m_en;
    acc = i_wb_cyc && !m_ack;
    if (acc) begin
      rv = 32'd0;
      case (i_wb_adr)
        2'd0: begin rv = 32'(pend_v); if (i_wb_we) clr_v = i_wb_dat[3:0] & EDGE; end
        2'd1: begin rv = 32'(m_en); if (i_wb_we) en_v = i_wb_dat[3:0]; end
        2'd2: begin
          rv = (lowest < 0) ? 32'd0 : 32'(lowest + 1);
          if (!i_wb_we && lowest >= 0) set_v[lowest] = 1'b1;
        end
        default: begin
          if (i_wb_we && i_wb_dat >= 32'd1 && i_wb_dat <= 32'(N)) cmp_v[i_wb_dat - 32'd1] = 1'b1;
        end
      endcase
      sb_q.push_back(rv);
    end
    for (int i = 0; i < N; i++) begin
      if (EDGE[i]) m_pend[i] = (m_pend[i] && !clr_v[i] && !set_v[i]) || (i_src[i] && !m_srcq[i]);
    end
    m_insvc = (m_insvc & ~cmp_v) | set_v;
    m_en    = en_v;
    m_irq   = (req_v != 4'd0);
    m_srcq  = i_src;
    m_ack   = acc;
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      model_step();
    end
  end

  // Monitor: irq/ack against the model, read data against the scoreboard
  initial begin
    forever begin
      @(negedge i_clk);
      check("irq", {31'd0, o_irq}, {31'd0, m_irq});
      check("ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
      if (o_wb_ack) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: ack with rdt %0h, no expected entry", o_wb_rdt);
        end else begin
          check("rdt", o_wb_rdt, sb_q.pop_front());
        end
      end
    end
  end

  // Single bus access; called #1 after a rising edge, returns #1 after the ack edge
  task automatic bus(input logic [1:0] adr, input logic [31:0] dat, input logic we,
                     output logic [31:0] rdt);
    int n = 0;
    rdt = 32'd0;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_we = we; i_wb_cyc = 1'b1;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_wb_ack && n < 8);
    if (!o_wb_ack) begin
      n_checks++;
      $display("FAIL bus_timeout: no ack after %0d cycles, expected ack", n);
    end else begin
      rdt = o_wb_rdt;
    end
    last_lat = n;
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    // Reset and idle
    wait_cyc(3);
    check("rst_irq", {31'd0, o_irq}, 32'd0);
    check("rst_rdt", o_wb_rdt, 32'd0);
    i_rst = 1'b0;
    wait_cyc(1);
    bus(2'd0, 32'd0, 1'b0, r); check("rst_pending", r, 32'd0);
    check("ack_latency", 32'(last_lat), 32'd1);
    bus(2'd1, 32'd0, 1'b0, r); check("rst_enable", r, 32'd0);
    bus(2'd2, 32'd0, 1'b0, r); check("rst_claim", r, 32'd0);
    bus(2'd3, 32'd0, 1'b0, r); check("rst_complete", r, 32'd0);

    // Timer edge on source 0
    bus(2'd1, 32'd1, 1'b1, r);
    wait_cyc(1);
    i_src = 4'b0001;
    wait_cyc(1); check("edge_lat1", {31'd0, o_irq}, 32'd0);
    wait_cyc(1); check("edge_lat2", {31'd0, o_irq}, 32'd1);
    bus(2'd2, 32'd0, 1'b0, r); check("claim_timer", r, 32'd1);
    wait_cyc(1); check("irq_drop", {31'd0, o_irq}, 32'd0);
    bus(2'd0, 32'd0, 1'b0, r); check("pend_after_claim", r, 32'd0);
    bus(2'd3, 32'd1, 1'b1, r);
    wait_cyc(2); check("irq_after_cmp", {31'd0, o_irq}, 32'd0);
    i_src = 4'd0;
    wait_cyc(2);

    // Edge src0 plus level src2
    bus(2'd1, 32'hF, 1'b1, r);
    i_src = 4'b0101;
    wait_cyc(3);
    bus(2'd2, 32'd0, 1'b0, r); check("claim1", r, 32'd1);
    bus(2'd2, 32'd0, 1'b0, r); check("claim2", r, 32'd3);
    bus(2'd2, 32'd0, 1'b0, r); check("claim3", r, 32'd0);
    wait_cyc(1); check("irq_all_insvc", {31'd0, o_irq}, 32'd0);
    bus(2'd3, 32'd3, 1'b1, r);
    wait_cyc(1); check("cmp3_reassert", {31'd0, o_irq}, 32'd1);
    bus(2'd3, 32'd1, 1'b1, r);
    i_src = 4'd0;
    wait_cyc(3);

    // New edge coincides with W1C of the same bit
    i_src = 4'b0001;
    bus(2'd0, 32'd1, 1'b1, r);
    bus(2'd0, 32'd0, 1'b0, r); check("edge_beats_w1c", r, 32'd1);
    bus(2'd0, 32'd1, 1'b1, r);
    bus(2'd0, 32'd0, 1'b0, r); check("w1c_clears", r, 32'd0);

    // Everything active but disabled
    bus(2'd1, 32'd0, 1'b1, r);
    i_src = 4'b1111;
    wait_cyc(3);
    check("disabled_irq", {31'd0, o_irq}, 32'd0);
    bus(2'd2, 32'd0, 1'b0, r); check("disabled_claim", r, 32'd0);
    bus(2'd1, 32'd4, 1'b1, r);
    check("en_irq_at_ack", {31'd0, o_irq}, 32'd0);
    wait_cyc(1); check("en_irq_after", {31'd0, o_irq}, 32'd1);

    // Reset during a claim: dropped, state cleared
    i_rst = 1'b1; i_src = 4'd0;
    i_wb_adr = 2'd2; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
    wait_cyc(2);
    check("rst_no_ack", {31'd0, o_wb_ack}, 32'd0);
    i_rst = 1'b0; i_wb_cyc = 1'b0;
    wait_cyc(1);
    bus(2'd0, 32'd0, 1'b0, r); check("rst_pend_clr", r, 32'd0);
    bus(2'd2, 32'd0, 1'b0, r); check("rst_insvc_clr", r, 32'd0);
    bus(2'd1, 32'd1, 1'b1, r);
    i_src = 4'b0001;
    wait_cyc(2);
    bus(2'd2, 32'd0, 1'b0, r); check("reissue_claim", r, 32'd1);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      @(posedge i_clk); #1;
      i_src = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        bus(2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 6)) : $urandom,
            1'($urandom_range(0, 1)), r);
      end
    end

    wait_cyc(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
